ultrasonic_scheduler: RTL and testbench

//  Round-robin sequencer for NUM_SENSORS HC-SR04-style rangers sharing one measurement timer.

---
 rtl/ultrasonic_pkg.sv | 25 ++
 rtl/ultrasonic_echo_sync.sv | 37 +++
 rtl/ultrasonic_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_ultrasonic_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// Shared state encoding, default timing constants and a small helper for the ultrasonic scheduler.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GUARD
  } state_e;

  // Defaults assume a 50 MHz clk.
  localparam int DEF_NUM_SENSORS  = 4;
  localparam int DEF_CNT_W        = 21;
  localparam int DEF_TRIG_CYCLES  = 500;
  localparam int DEF_RISE_TIMEOUT = 50000;
  localparam int DEF_ECHO_MAX     = 1200000;
  localparam int DEF_GUARD_CYCLES = 3000000;
  localparam int DEF_NEAR_THRESH  = 28012;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ultrasonic_echo_sync.sv
// Two-flop synchronizer for raw echo pins with single-cycle rise/fall pulses on the synchronized value.
module ultrasonic_echo_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_scheduler.sv
// Round-robin HC-SR04 scheduler sharing one timer across NUM_SENSORS rangers.
// Define ULTRASONIC_HYST_EN to require two agreeing results before a near flag changes.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | scan stopped; waits for enable
//   TRIG      | trig[idx] high, timer counts TRIG_CYCLES down
//   WAIT_RISE | waits for a 0->1 echo edge, timer counts RISE_TIMEOUT down
//   MEASURE   | timer counts echo-high cycles up, saturating at ECHO_MAX
//   GUARD     | crosstalk gap, timer counts GUARD_CYCLES down, then next sensor
module ultrasonic_scheduler
  import ultrasonic_pkg::*;
#(
  parameter int NUM_SENSORS  = DEF_NUM_SENSORS,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int TRIG_CYCLES  = DEF_TRIG_CYCLES,
  parameter int RISE_TIMEOUT = DEF_RISE_TIMEOUT,
  parameter int ECHO_MAX     = DEF_ECHO_MAX,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int NEAR_THRESH  = DEF_NEAR_THRESH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [NUM_SENSORS-1:0]         echo,
  output logic [NUM_SENSORS-1:0]         trig,
  output logic                           dist_valid,
  output logic [$clog2(NUM_SENSORS)-1:0] dist_id,
  output logic [CNT_W-1:0]               dist_cycles,
  output logic [NUM_SENSORS-1:0]         near,
  output logic                           timeout_err
);

  localparam int ID_W  = $clog2(NUM_SENSORS);
  // The guard gap can outgrow the distance width, so the shared timer is sized for the largest load.
  localparam int TMR_W = max_int(CNT_W, max_int($clog2(GUARD_CYCLES + 1),
                                 max_int($clog2(RISE_TIMEOUT + 1), $clog2(TRIG_CYCLES + 1))));

  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam logic [TMR_W-1:0] TRIG_LD    = TMR_W'(TRIG_CYCLES - 1);
  localparam logic [TMR_W-1:0] RISE_LD    = TMR_W'(RISE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GUARD_LD   = TMR_W'(GUARD_CYCLES - 1);
  localparam logic [TMR_W-1:0] ECHO_MAX_T = TMR_W'(ECHO_MAX);
  localparam logic [CNT_W-1:0] ECHO_MAX_C = CNT_W'(ECHO_MAX);
  localparam logic [CNT_W-1:0] NEAR_C     = CNT_W'(NEAR_THRESH);
  localparam logic [ID_W-1:0]  LAST_IDX   = ID_W'(NUM_SENSORS - 1);
  localparam logic [ID_W-1:0]  ID_ONE     = ID_W'(1);
`ifdef ULTRASONIC_HYST_EN
  localparam logic [CNT_W-1:0] FAR_C      = CNT_W'(NEAR_THRESH + NEAR_THRESH / 8);
`endif

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        idx_q, idx_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [NUM_SENSORS-1:0] trig_q, trig_d;
  logic                   dist_valid_q, dist_valid_d;
  logic [ID_W-1:0]        dist_id_q, dist_id_d;
  logic [CNT_W-1:0]       dist_cycles_q, dist_cycles_d;
  logic [NUM_SENSORS-1:0] near_q, near_d;
  logic                   timeout_err_q, timeout_err_d;
`ifdef ULTRASONIC_HYST_EN
  logic [NUM_SENSORS-1:0] hist_q, hist_d;
  logic                   result_far;
`endif

  logic [NUM_SENSORS-1:0] echo_rise, echo_fall;
  logic                   rise_sel, fall_sel;
  logic                   result_set, result_to, result_near;
  logic [CNT_W-1:0]       result_val;

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_sync
    ultrasonic_echo_sync #(.WIDTH(1)) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_in(echo[i]),
      .rise    (echo_rise[i]),
      .fall    (echo_fall[i])
    );
  end

  assign rise_sel = echo_rise[idx_q];
  assign fall_sel = echo_fall[idx_q];

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    dist_valid_d  = 1'b0;
    timeout_err_d = 1'b0;
    dist_id_d     = dist_id_q;
    dist_cycles_d = dist_cycles_q;
    result_set    = 1'b0;
    result_to     = 1'b0;
    result_val    = '0;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (enable) begin
          state_d = TRIG;
          timer_d = TRIG_LD;
        end
      end
      TRIG: begin
        if (timer_q == '0) begin
          state_d = WAIT_RISE;
          timer_d = RISE_LD;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      WAIT_RISE: begin
        if (rise_sel) begin
          state_d = MEASURE;
          timer_d = '0;
        end else if (timer_q == '0) begin
          result_set = 1'b1;
          result_to  = 1'b1;
          result_val = ECHO_MAX_C;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      MEASURE: begin
        if (fall_sel) begin
          result_set = 1'b1;
          result_val = CNT_W'(timer_q);
        end else if (timer_q >= ECHO_MAX_T) begin
          result_set = 1'b1;
          result_to  = 1'b1;
          result_val = ECHO_MAX_C;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      GUARD: begin
        if (timer_q == '0) begin
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + ID_ONE;
          state_d = enable ? TRIG : IDLE;
          timer_d = enable ? TRIG_LD : '0;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    if (result_set) begin
      state_d       = GUARD;
      timer_d       = GUARD_LD;
      dist_valid_d  = 1'b1;
      timeout_err_d = result_to;
      dist_id_d     = idx_q;
      dist_cycles_d = result_val;
    end

    // Registered one-hot trigger keeps the pins glitch-free and aligned with state_q == TRIG.
    trig_d = '0;
    if (state_d == TRIG) trig_d[idx_d] = 1'b1;
  end

  always_comb begin
    near_d      = near_q;
    result_near = !result_to && (result_val < NEAR_C);
`ifdef ULTRASONIC_HYST_EN
    hist_d      = hist_q;
    result_far  = result_to || (result_val >= FAR_C);
    // hist marks that the previous result already pointed towards the opposite flag value.
    if (result_set) begin
      if (!near_q[idx_q]) begin
        if (result_near && hist_q[idx_q]) begin
          near_d[idx_q] = 1'b1;
          hist_d[idx_q] = 1'b0;
        end else begin
          hist_d[idx_q] = result_near;
        end
      end else begin
        if (result_far && hist_q[idx_q]) begin
          near_d[idx_q] = 1'b0;
          hist_d[idx_q] = 1'b0;
        end else begin
          hist_d[idx_q] = result_far;
        end
      end
    end
`else
    if (result_set) near_d[idx_q] = result_near;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      timer_q       <= '0;
      trig_q        <= '0;
      dist_valid_q  <= 1'b0;
      dist_id_q     <= '0;
      dist_cycles_q <= '0;
      near_q        <= '0;
      timeout_err_q <= 1'b0;
`ifdef ULTRASONIC_HYST_EN
      hist_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      trig_q        <= trig_d;
      dist_valid_q  <= dist_valid_d;
      dist_id_q     <= dist_id_d;
      dist_cycles_q <= dist_cycles_d;
      near_q        <= near_d;
      timeout_err_q <= timeout_err_d;
`ifdef ULTRASONIC_HYST_EN
      hist_q        <= hist_d;
`endif
    end
  end

  assign trig        = trig_q;
  assign dist_valid  = dist_valid_q;
  assign dist_id     = dist_id_q;
  assign dist_cycles = dist_cycles_q;
  assign near        = near_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Scenario bench for ultrasonic_scheduler with a result scoreboard and a near-flag model.
module tb_ultrasonic_scheduler;

  localparam int NS     = 2;
  localparam int CW     = 12;
  localparam int TRIGC  = 10;
  localparam int RISET  = 50;
  localparam int EMAX   = 200;
  localparam int GUARDC = 20;
  localparam int NEAR_T = 150;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [NS-1:0] echo = '0;
  logic [NS-1:0] trig;
  logic          dist_valid;
  logic [0:0]    dist_id;
  logic [CW-1:0] dist_cycles;
  logic [NS-1:0] near;
  logic          timeout_err;

  always #5 clk = ~clk;

  ultrasonic_scheduler #(
    .NUM_SENSORS (NS),
    .CNT_W       (CW),
    .TRIG_CYCLES (TRIGC),
    .RISE_TIMEOUT(RISET),
    .ECHO_MAX    (EMAX),
    .GUARD_CYCLES(GUARDC),
    .NEAR_THRESH (NEAR_T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .echo       (echo),
    .trig       (trig),
    .dist_valid (dist_valid),
    .dist_id    (dist_id),
    .dist_cycles(dist_cycles),
    .near       (near),
    .timeout_err(timeout_err)
  );

  typedef struct {
    int          id;
    int          cycles;
    int          tol;
    bit          to;
    logic [NS-1:0] nearv;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  logic [NS-1:0] mdl_near = '0;
`ifdef ULTRASONIC_HYST_EN
  logic [NS-1:0] mdl_hist = '0;
`endif

  task automatic push_exp(input int id, input int cycles, input int tol, input bit to);
    exp_t e;
    bit   below;
    below = !to && (cycles < NEAR_T);
`ifdef ULTRASONIC_HYST_EN
    begin
      bit above;
      above = to || (cycles >= NEAR_T + NEAR_T / 8);
      if (!mdl_near[id]) begin
        if (below && mdl_hist[id]) begin mdl_near[id] = 1'b1; mdl_hist[id] = 1'b0; end
        else mdl_hist[id] = below;
      end else begin
        if (above && mdl_hist[id]) begin mdl_near[id] = 1'b0; mdl_hist[id] = 1'b0; end
        else mdl_hist[id] = above;
      end
    end
`else
    mdl_near[id] = below;
`endif
    e.id = id; e.cycles = cycles; e.tol = tol; e.to = to; e.nearv = mdl_near;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && dist_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: dist_id=%0d dist_cycles=%0d, none expected", dist_id, dist_cycles);
      end else begin
        mon_e = sb.pop_front();
        if (int'(dist_id) !== mon_e.id) begin
          errors++;
          $display("FAIL result_id: got %0d expected %0d", dist_id, mon_e.id);
        end
        checks++;
        if ($isunknown(dist_cycles) || int'(dist_cycles) < mon_e.cycles - mon_e.tol ||
            int'(dist_cycles) > mon_e.cycles + mon_e.tol) begin
          errors++;
          $display("FAIL result_cycles: got %0d expected %0d +/- %0d", dist_cycles, mon_e.cycles, mon_e.tol);
        end
        checks++;
        if (timeout_err !== mon_e.to) begin
          errors++;
          $display("FAIL result_timeout_err: got %b expected %b", timeout_err, mon_e.to);
        end
        checks++;
        if (near !== mon_e.nearv) begin
          errors++;
          $display("FAIL result_near: got %b expected %b", near, mon_e.nearv);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; echo = '0;
    repeat (3) @(negedge clk);
    checks++; if (trig !== 2'b00) begin errors++; $display("FAIL reset_trig: got %b expected 00", trig); end
    checks++; if (dist_valid !== 1'b0) begin errors++; $display("FAIL reset_dist_valid: got %b expected 0", dist_valid); end
    checks++; if (dist_id !== 1'b0) begin errors++; $display("FAIL reset_dist_id: got %0d expected 0", dist_id); end
    checks++; if (dist_cycles !== '0) begin errors++; $display("FAIL reset_dist_cycles: got %0d expected 0", dist_cycles); end
    checks++; if (near !== 2'b00) begin errors++; $display("FAIL reset_near: got %b expected 00", near); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_trigger();
    int wait_c = 0;
    int high_c = 0;
    bit other = 1'b0;
    enable = 1'b1;
    do begin @(negedge clk); wait_c++; end while (trig == 2'b00 && wait_c < 10);
    checks++;
    if (trig !== 2'b01) begin errors++; $display("FAIL trig0_start: got %b expected 01", trig); end
    while (trig[0] === 1'b1 && high_c < 30) begin
      if (trig[1] !== 1'b0) other = 1'b1;
      high_c++;
      @(negedge clk);
    end
    checks++;
    if (high_c != TRIGC) begin errors++; $display("FAIL trig0_width: got %0d cycles expected %0d", high_c, TRIGC); end
    checks++;
    if (other) begin errors++; $display("FAIL trig1_quiet: got trig[1]=1 during sensor 0 trigger, expected 0"); end
  endtask

  task automatic test_measure();
    push_exp(0, 100, 1, 1'b0);
    echo[0] = 1'b1;
    repeat (100) @(negedge clk);
    echo[0] = 1'b0;
    for (int c = 0; c < 60 && sb.size() != 0; c++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL measure_done: got %0d pending results expected 0", sb.size()); end
  endtask

  task automatic test_timeout();
    int c = 0;
    for (int w = 0; w < 40 && trig == 2'b00; w++) @(negedge clk);
    checks++;
    if (trig !== 2'b10) begin errors++; $display("FAIL trig1_start: got %b expected 10", trig); end
    for (int w = 0; w < 20 && trig != 2'b00; w++) @(negedge clk);
    push_exp(1, EMAX, 0, 1'b1);
    while (dist_valid !== 1'b1 && c < 100) begin @(negedge clk); c++; end
    checks++;
    if (c < RISET - 1 || c > RISET + 1) begin
      errors++; $display("FAIL rise_timeout_delay: got %0d cycles expected %0d +/- 1", c, RISET);
    end
    for (int w = 0; w < 5 && sb.size() != 0; w++) @(negedge clk);
  endtask

  task automatic test_saturate();
    int   t_valid = -1;
    int   t_trig = -1;
    logic [NS-1:0] trig_at = '0;
    bit   done = 1'b0;
    for (int w = 0; w < 40 && trig == 2'b00; w++) @(negedge clk);
    for (int w = 0; w < 20 && trig != 2'b00; w++) @(negedge clk);
    push_exp(0, EMAX, 0, 1'b1);
    push_exp(1, EMAX, 0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      echo[0] = (i < 300);
      @(negedge clk);
      if (dist_valid === 1'b1 && t_valid < 0) t_valid = i;
      if (trig != 2'b00 && t_valid >= 0 && t_trig < 0) begin t_trig = i; trig_at = trig; end
      if (trig[0] === 1'b1 && i > 300) begin done = 1'b1; break; end
    end
    checks++;
    if (t_valid < 0 || t_trig < 0 || t_trig - t_valid < GUARDC) begin
      errors++; $display("FAIL guard_gap: got %0d cycles expected >= %0d", t_trig - t_valid, GUARDC);
    end
    checks++;
    if (trig_at !== 2'b10) begin errors++; $display("FAIL trig_after_saturate: got %b expected 10", trig_at); end
    checks++;
    if (!done || sb.size() != 0) begin
      errors++; $display("FAIL saturate_sequence: got done=%0d pending=%0d expected done=1 pending=0", done, sb.size());
    end
  endtask

  task automatic test_enable_drop();
    bit fired = 1'b0;
    for (int w = 0; w < 20 && trig != 2'b00; w++) @(negedge clk);
    push_exp(0, 60, 1, 1'b0);
    echo[0] = 1'b1;
    repeat (20) @(negedge clk);
    enable = 1'b0;
    repeat (40) @(negedge clk);
    echo[0] = 1'b0;
    for (int c = 0; c < 40 && sb.size() != 0; c++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL enable_drop_result: got %0d pending results expected 0", sb.size()); end
    repeat (100) begin
      @(negedge clk);
      if (trig != 2'b00) fired = 1'b1;
    end
    checks++;
    if (fired) begin errors++; $display("FAIL idle_after_disable: got a trigger pulse, expected none"); end
  endtask

  task automatic test_reset_mid_trig();
    enable = 1'b1;
    for (int w = 0; w < 5 && trig == 2'b00; w++) @(negedge clk);
    checks++;
    if (trig !== 2'b10) begin errors++; $display("FAIL idx_advanced: got trig %b expected 10", trig); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (trig !== 2'b00) begin errors++; $display("FAIL async_trig: got %b expected 00", trig); end
    checks++; if (dist_valid !== 1'b0) begin errors++; $display("FAIL async_dist_valid: got %b expected 0", dist_valid); end
    checks++; if (dist_id !== 1'b0) begin errors++; $display("FAIL async_dist_id: got %0d expected 0", dist_id); end
    checks++; if (dist_cycles !== '0) begin errors++; $display("FAIL async_dist_cycles: got %0d expected 0", dist_cycles); end
    checks++; if (near !== 2'b00) begin errors++; $display("FAIL async_near: got %b expected 00", near); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL async_timeout_err: got %b expected 0", timeout_err); end
    mdl_near = '0;
`ifdef ULTRASONIC_HYST_EN
    mdl_hist = '0;
`endif
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int w = 0; w < 5 && trig == 2'b00; w++) @(negedge clk);
    checks++;
    if (trig !== 2'b01) begin errors++; $display("FAIL restart_sensor0: got trig %b expected 01", trig); end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_measure();
    test_timeout();
    test_saturate();
    test_enable_drop();
    test_reset_mid_trig();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
